// File: rtl/decoder_ctrl_pkg.sv
// Shared types and helpers for the decoder select control stage.
package decoder_ctrl_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } ctrl_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam int   SEL_W    = 2;

  // Counter width for a modulus n: $clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] sel,
                                                   input logic             dir);
    if (dir == DIR_UP) begin
      return sel + SEL_W'(1);
    end else begin
      return sel - SEL_W'(1);
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// registered one-cycle pulse on each accepted press.
module btn_debounce
  import decoder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pressed
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic             pressed_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, count consecutive differing cycles, accept the level, detect rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      pressed_r  <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      sync1_r    <= btn_raw;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      pressed_r  <= stable_r & ~stable_d_r;
      if (sync2_r == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync2_r;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign pressed = pressed_r;

endmodule

// File: rtl/decoder_select_ctrl.sv
// Select/enable generator for the 2-to-4 LED decoder: manual stepping by
// button or timed auto scan, gated by a synchronized enable switch.
module decoder_select_ctrl
  import decoder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_CYCLES     = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             dir,
  input  logic             en_in,
  output logic [SEL_W-1:0] a,
  output logic             en,
  output logic             auto_mode
);

  localparam int                 SCAN_W    = cnt_width(SCAN_CYCLES);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic              step_pulse_s;
  logic              mode_pulse_s;
  logic              en_sync1_r;
  logic              en_sync2_r;
  ctrl_state_e       state_r;
  ctrl_state_e       state_next_s;
  logic [SCAN_W-1:0] scan_r;
  logic [SCAN_W-1:0] scan_next_s;
  logic [SEL_W-1:0]  a_r;
  logic [SEL_W-1:0]  a_next_s;
  logic              auto_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_step),
    .pressed (step_pulse_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .pressed (mode_pulse_s)
  );

  // Mode toggle outranks any advance; a low enable freezes both select and scan count.
  always_comb begin
    state_next_s = state_r;
    scan_next_s  = scan_r;
    a_next_s     = a_r;
    if (mode_pulse_s) begin
      state_next_s = (state_r == MANUAL) ? AUTO : MANUAL;
      scan_next_s  = {SCAN_W{1'b0}};
    end else begin
      case (state_r)
        MANUAL: begin
          if (en_sync2_r && step_pulse_s) begin
            a_next_s = sel_advance(a_r, dir);
          end else begin
            a_next_s = a_r;
          end
        end
        AUTO: begin
          if (!en_sync2_r) begin
            scan_next_s = scan_r;
          end else if (scan_r == SCAN_LAST) begin
            scan_next_s = {SCAN_W{1'b0}};
            a_next_s    = sel_advance(a_r, dir);
          end else begin
            scan_next_s = scan_r + SCAN_W'(1);
          end
        end
        default: begin
          state_next_s = MANUAL;
          scan_next_s  = {SCAN_W{1'b0}};
        end
      endcase
    end
  end

  // State, scan counter, select and enable synchronizer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync1_r <= 1'b0;
      en_sync2_r <= 1'b0;
      state_r    <= MANUAL;
      scan_r     <= {SCAN_W{1'b0}};
      a_r        <= {SEL_W{1'b0}};
      auto_r     <= 1'b0;
    end else begin
      en_sync1_r <= en_in;
      en_sync2_r <= en_sync1_r;
      state_r    <= state_next_s;
      scan_r     <= scan_next_s;
      a_r        <= a_next_s;
      auto_r     <= (state_next_s == AUTO);
    end
  end

  assign a         = a_r;
  assign en        = en_sync2_r;
  assign auto_mode = auto_r;

endmodule

// File: tb/tb_decoder_select_ctrl.sv
// Bench for decoder_select_ctrl: directed vector table, hand sequences for
// scan/enable/reset corners, and random stimulus against a history-based model.
module tb_decoder_select_ctrl;

  localparam int D    = 4;
  localparam int S    = 8;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_mode = 1'b0;
  logic       dir = 1'b0;
  logic       en_in = 1'b0;
  logic [1:0] a;
  logic       en;
  logic       auto_mode;

  always #5 clk = ~clk;

  decoder_select_ctrl #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .dir       (dir),
    .en_in     (en_in),
    .a         (a),
    .en        (en),
    .auto_mode (auto_mode)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw input history per edge; a button level is accepted
  // once D consecutive synchronized samples differ from the accepted level.
  bit hist [0:2][0:MAXC-1];
  int cyc    = 0;
  int r_last = -1;
  bit m_valid = 1'b0;
  int m_a, m_scan;
  bit m_auto, m_en_out;
  bit m_st   [0:1];
  bit m_rose [0:1];
  bit m_p    [0:1];

  function automatic bit smp(input int w, input int j);
    if (j < 0 || j <= r_last) return 1'b0;
    return hist[w][j];
  endfunction

  function automatic bit accept_now(input int w, input bit st, input int k);
    for (int i = 2; i <= D + 1; i++) begin
      if (smp(w, k - i) == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input int k, input bit r, input bit d);
    bit en_eff, sp, mp, fl;
    if (r) begin
      r_last = k; m_valid = 1'b1;
      m_a = 0; m_scan = 0; m_auto = 1'b0; m_en_out = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_st[w] = 1'b0; m_rose[w] = 1'b0; m_p[w] = 1'b0;
      end
      return;
    end
    en_eff = smp(2, k - 2);
    sp = m_p[0];
    mp = m_p[1];
    for (int w = 0; w < 2; w++) begin
      m_p[w] = m_rose[w];
      fl = accept_now(w, m_st[w], k);
      m_rose[w] = fl && !m_st[w];
      if (fl) m_st[w] = !m_st[w];
    end
    if (mp) begin
      m_auto = !m_auto;
      m_scan = 0;
    end else if (m_auto) begin
      if (en_eff) begin
        if (m_scan == S - 1) begin
          m_scan = 0;
          m_a = d ? (m_a + 3) % 4 : (m_a + 1) % 4;
        end else begin
          m_scan = m_scan + 1;
        end
      end
    end else if (sp && en_eff) begin
      m_a = d ? (m_a + 3) % 4 : (m_a + 1) % 4;
    end
    m_en_out = smp(2, k - 1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d want=%0d", cyc, cyc, MAXC - 1);
      $fatal(1, "cycle budget exceeded");
    end
    hist[0][cyc] = btn_step;
    hist[1][cyc] = btn_mode;
    hist[2][cyc] = en_in;
    model_edge(cyc, rst, dir);
    #1;
    if (m_valid) begin
      chk("model_a", int'(a), m_a);
      chk("model_en", int'(en), int'(m_en_out));
      chk("model_auto", int'(auto_mode), int'(m_auto));
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit r, step, mode, d, e;
    int n;
    int ea, een, eauto;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit step, bit mode, bit d, bit e, int n,
                              int ea, int een, int eauto);
    vec_t v;
    v.r = r; v.step = step; v.mode = mode; v.d = d; v.e = e; v.n = n;
    v.ea = ea; v.een = een; v.eauto = eauto;
    return v;
  endfunction

  initial begin
    // reset, enable latency
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
    // bounce 1,0,1,0 then hold: advance lands on the 8th held edge
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 7, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 5, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 10, 1, 1, 0));
    // clean presses counting up, wrap 3->0
    tbl.push_back(mk(0, 1, 0, 0, 1, 8, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8, 3, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8, 1, 1, 0));
    // counting down, wrap 0->3
    tbl.push_back(mk(0, 1, 0, 1, 1, 8, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 8, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8, 3, 1, 0));
    // enter AUTO, then one advance per 8 cycles
    tbl.push_back(mk(0, 0, 1, 0, 1, 8, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8, 1, 1, 1));

    foreach (tbl[i]) begin
      rst = tbl[i].r; btn_step = tbl[i].step; btn_mode = tbl[i].mode;
      dir = tbl[i].d; en_in = tbl[i].e;
      run(tbl[i].n);
      chk($sformatf("tbl%0d_a", i), int'(a), tbl[i].ea);
      chk($sformatf("tbl%0d_en", i), int'(en), tbl[i].een);
      chk($sformatf("tbl%0d_auto", i), int'(auto_mode), tbl[i].eauto);
    end

    // step press during AUTO does not disturb the cadence
    btn_step = 1'b1; run(8);
    btn_step = 1'b0; run(8);
    chk("auto_step_ignored", int'(a), 3);

    // simultaneous mode+step, also landing on the scan terminal count
    btn_step = 1'b1; btn_mode = 1'b1; run(8);
    chk("simul_to_manual_auto", int'(auto_mode), 0);
    chk("simul_to_manual_a", int'(a), 3);
    btn_step = 1'b0; btn_mode = 1'b0; run(8);
    btn_step = 1'b1; btn_mode = 1'b1; run(8);
    chk("simul_to_auto_auto", int'(auto_mode), 1);
    chk("simul_to_auto_a", int'(a), 3);
    btn_step = 1'b0; btn_mode = 1'b0; run(8);
    chk("auto_first_adv", int'(a), 0);

    // enable drop with the scan count freezing at 5
    run(3);
    en_in = 1'b0;
    run(1); chk("en_drop_lat1", int'(en), 1);
    run(1); chk("en_drop_lat2", int'(en), 0);
    run(20); chk("en_frozen_a", int'(a), 0);
    en_in = 1'b1;
    run(1); chk("en_rise_lat1", int'(en), 0);
    run(1); chk("en_rise_lat2", int'(en), 1);
    run(2); chk("resume_before", int'(a), 0);
    run(1); chk("resume_adv", int'(a), 1);

    // reset mid-AUTO with step mid-debounce
    run(8); chk("pre_reset_a", int'(a), 2);
    btn_step = 1'b1; run(2);
    rst = 1'b1; btn_step = 1'b0; run(1);
    chk("midrst_a", int'(a), 0);
    chk("midrst_auto", int'(auto_mode), 0);
    chk("midrst_en", int'(en), 0);
    rst = 1'b0; run(12);
    chk("post_rst_a", int'(a), 0);
    chk("post_rst_auto", int'(auto_mode), 0);
    chk("post_rst_en", int'(en), 1);

    // random bouncy stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 49) == 0) en_in = ~en_in;
      if ($urandom_range(0, 99) == 0) dir = ~dir;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
